// File: rtl/ghost_dir_ctrl.sv
// ghost_dir_ctrl: autonomous WASD direction source for one ghost mover.
module ghost_dir_ctrl #(
  parameter int unsigned DECIDE_FRAMES = 8,
  parameter logic [9:0]  SCATTER_X     = 10'd600,
  parameter logic [9:0]  SCATTER_Y     = 10'd20,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       frame_tick_i,
  input  logic       enable_i,
  input  logic [1:0] mode_i,
  input  logic [9:0] GhostX_i,
  input  logic [9:0] GhostY_i,
  input  logic [9:0] TargetX_i,
  input  logic [9:0] TargetY_i,
  input  logic [3:0] No_Move_i,
  output logic [7:0] keycode_o,
  output logic       dir_valid_o
);
  typedef enum logic [1:0] {IDLE, RUN, SAMPLE, COMMIT} state_t;
  // direction codes double as bit indices into No_Move {up,down,left,right}
  localparam logic [1:0] R = 2'd0, L = 2'd1, D = 2'd2, U = 2'd3;
  localparam logic [7:0] FRIGHT = {U, L, D, R};
  localparam logic [7:0] LAST = 8'(DECIDE_FRAMES - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, key_q, key_d;
  logic [1:0] cur_q, cur_d, mode_q, ms_q;
  logic cur_vld_q, cur_vld_d, rev_q, rev_d, dv_q, dv_d;
  logic [15:0] lfsr_q, lfsr_d, fr;
  logic [9:0] gx_q, gy_q, tx_q, ty_q, adx, ady;
  logic [3:0] nm_q;
  logic [10:0] dx, dy, ndx, ndy;
  logic [1:0] tox, toy, p, s, sel, rdir, new_dir;
  logic [3:0][1:0] cand;
  logic halt, trigger, sample, commit, sel_vld, use_rev, new_vld;

  assign halt = !enable_i | (mode_i == 2'b11);
  assign trigger = (cnt_q == LAST) | !cur_vld_q | No_Move_i[cur_q] | rev_q;
  assign sample = (state_q == RUN) & frame_tick_i & trigger & !halt;
  assign commit = (state_q == SAMPLE) & !halt;
  assign rdir = cur_q ^ 2'd1;
  assign keycode_o = key_q;
  assign dir_valid_o = dv_q;

  always_ff @(posedge Clk_i or posedge Reset_i)
    if (Reset_i) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = halt ? IDLE : state_q == IDLE ? RUN : state_q == RUN ? (sample ? SAMPLE : RUN) :
              state_q == SAMPLE ? COMMIT : RUN;

  always_comb begin
    dx = {1'b0, tx_q} - {1'b0, gx_q};
    dy = {1'b0, ty_q} - {1'b0, gy_q};
    ndx = 11'd0 - dx;
    ndy = 11'd0 - dy;
    adx = dx[10] ? ndx[9:0] : dx[9:0];
    ady = dy[10] ? ndy[9:0] : dy[9:0];
    tox = dx[10] ? L : R;
    toy = dy[10] ? U : D;
    p = (adx >= ady) ? tox : toy;
    s = (adx >= ady) ? toy : tox;
    fr = {FRIGHT, FRIGHT} << {lfsr_q[1:0], 1'b0};
    cand = (ms_q == 2'b10) ? {fr[9:8], fr[11:10], fr[13:12], fr[15:14]} : {p ^ 2'd1, s ^ 2'd1, s, p};
    sel_vld = 1'b0;
    sel = R;
    for (int i = 3; i >= 0; i--)
      if (!nm_q[cand[i]] && !(cur_vld_q && cand[i] == rdir)) begin
        sel_vld = 1'b1;
        sel = cand[i];
      end
    use_rev = cur_vld_q & !nm_q[rdir] & (rev_q | !sel_vld);
    new_vld = use_rev | sel_vld;
    new_dir = use_rev ? rdir : sel;
  end

  always_comb begin
    cnt_d = (state_q == RUN && frame_tick_i && !halt) ? ((rev_q || cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1) : cnt_q;
    cur_d = commit ? new_dir : cur_q;
    cur_vld_d = halt ? 1'b0 : commit ? new_vld : cur_vld_q;
    key_d = halt ? 8'h00 : !commit ? key_q : !new_vld ? 8'h00 :
            new_dir == R ? 8'h07 : new_dir == L ? 8'h04 : new_dir == D ? 8'h16 : 8'h1A;
    dv_d = commit;
    rev_d = (mode_q != mode_i && mode_q != 2'b11 && mode_i != 2'b11) || (rev_q && !commit);
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge Clk_i or posedge Reset_i)
    if (Reset_i) begin
      cnt_q <= 8'd0;
      key_q <= 8'h00;
      cur_q <= R;
      cur_vld_q <= 1'b0;
      rev_q <= 1'b0;
      dv_q <= 1'b0;
      mode_q <= 2'b00;
      lfsr_q <= LFSR_SEED;
    end else begin
      cnt_q <= cnt_d;
      key_q <= key_d;
      cur_q <= cur_d;
      cur_vld_q <= cur_vld_d;
      rev_q <= rev_d;
      dv_q <= dv_d;
      mode_q <= mode_i;
      lfsr_q <= lfsr_d;
    end

  // decision snapshot taken on the RUN->SAMPLE transition
  always_ff @(posedge Clk_i or posedge Reset_i)
    if (Reset_i) begin
      gx_q <= '0;
      gy_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      nm_q <= '0;
      ms_q <= 2'b00;
    end else if (sample) begin
      gx_q <= GhostX_i;
      gy_q <= GhostY_i;
      tx_q <= (mode_i == 2'b01) ? SCATTER_X : TargetX_i;
      ty_q <= (mode_i == 2'b01) ? SCATTER_Y : TargetY_i;
      nm_q <= No_Move_i;
      ms_q <= mode_i;
    end
endmodule
